// File: rtl/stg3ex.sv
// rtl/stg3ex.sv - execute stage: single-cycle ALU plus iterative shift-add MUL
module stg3ex #(
  localparam int SIZE_ADDR = 16,
  localparam int SIZE_DATA = 16
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst_n,
  input  logic                 iw_valid,
  input  logic                 iw_flush,
  input  logic [SIZE_ADDR-1:0] iw_pc,
  input  logic [SIZE_DATA-1:0] iw_instr,
  input  logic [2:0]           iw_op,
  input  logic [SIZE_DATA-1:0] iw_opa,
  input  logic [SIZE_DATA-1:0] iw_opb,
  output logic                 ow_stall,
  output logic                 ow_valid,
  output logic [SIZE_ADDR-1:0] ow_pc,
  output logic [SIZE_DATA-1:0] ow_instr,
  output logic [SIZE_DATA-1:0] ow_result,
  output logic [1:0]           ow_flags
);

  localparam int CW = $clog2(SIZE_DATA);
  localparam logic [SIZE_DATA-1:0] LP_DATA_W = SIZE_DATA'(SIZE_DATA);
  localparam logic [CW-1:0] LP_LAST_CNT = CW'(SIZE_DATA - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t               r_state;
  logic [SIZE_ADDR-1:0] r_mul_pc;
  logic [SIZE_DATA-1:0] r_mul_instr;
  logic [SIZE_DATA-1:0] r_mcand;
  logic [SIZE_DATA-1:0] r_mplier;
  logic [SIZE_DATA-1:0] r_acc;
  logic [CW-1:0]        r_count;

  logic [SIZE_DATA-1:0] w_result;
  logic                 w_carry;
  logic                 w_shamt_big;
  logic [SIZE_DATA-1:0] w_acc_next;

  assign w_shamt_big = (iw_opb >= LP_DATA_W);
  assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign ow_stall    = (r_state == ST_MUL);

  // Single-cycle ALU result and carry/borrow for the presented operands
  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (iw_op)
      OP_ADD:  {w_carry, w_result} = {1'b0, iw_opa} + {1'b0, iw_opb};
      OP_SUB:  {w_carry, w_result} = {1'b0, iw_opa} - {1'b0, iw_opb};
      OP_AND:  w_result = iw_opa & iw_opb;
      OP_OR:   w_result = iw_opa | iw_opb;
      OP_XOR:  w_result = iw_opa ^ iw_opb;
      OP_SHL:  w_result = w_shamt_big ? '0 : (iw_opa << iw_opb);
      OP_SHR:  w_result = w_shamt_big ? '0 : (iw_opa >> iw_opb);
      default: w_result = '0;
    endcase
  end

  // Control FSM, MUL iteration and registered outputs to the memory stage
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state     <= ST_IDLE;
      r_mul_pc    <= '0;
      r_mul_instr <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      ow_valid    <= 1'b0;
      ow_pc       <= '0;
      ow_instr    <= '0;
      ow_result   <= '0;
      ow_flags    <= 2'b00;
    end else begin
      // bubble by default; branches that retire an instruction override this
      ow_valid  <= 1'b0;
      ow_pc     <= '0;
      ow_instr  <= '0;
      ow_result <= '0;
      if (iw_flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (iw_valid && (iw_op != OP_MUL)) begin
              ow_valid  <= 1'b1;
              ow_pc     <= iw_pc;
              ow_instr  <= iw_instr;
              ow_result <= w_result;
              ow_flags  <= {(w_result == '0), w_carry};
            end else if (iw_valid) begin
              r_mul_pc    <= iw_pc;
              r_mul_instr <= iw_instr;
              r_mcand     <= iw_opa;
              r_mplier    <= iw_opb;
              r_acc       <= '0;
              r_count     <= LP_LAST_CNT;
              r_state     <= ST_MUL;
            end
          end
          ST_MUL: begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - 1'b1;
            if (r_count == '0) begin
              ow_valid  <= 1'b1;
              ow_pc     <= r_mul_pc;
              ow_instr  <= r_mul_instr;
              ow_result <= w_acc_next;
              ow_flags  <= {(w_acc_next == '0), 1'b0};
              r_state   <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stg3ex.sv
// tb/tb_stg3ex.sv - directed self-checking bench for stg3ex
module tb_stg3ex;

  logic        iw_clk;
  logic        iw_rst_n;
  logic        iw_valid;
  logic        iw_flush;
  logic [15:0] iw_pc;
  logic [15:0] iw_instr;
  logic [2:0]  iw_op;
  logic [15:0] iw_opa;
  logic [15:0] iw_opb;
  logic        ow_stall;
  logic        ow_valid;
  logic [15:0] ow_pc;
  logic [15:0] ow_instr;
  logic [15:0] ow_result;
  logic [1:0]  ow_flags;

  int n_checks = 0;
  int n_errors = 0;

  stg3ex dut (
    .iw_clk    (iw_clk),
    .iw_rst_n  (iw_rst_n),
    .iw_valid  (iw_valid),
    .iw_flush  (iw_flush),
    .iw_pc     (iw_pc),
    .iw_instr  (iw_instr),
    .iw_op     (iw_op),
    .iw_opa    (iw_opa),
    .iw_opb    (iw_opb),
    .ow_stall  (ow_stall),
    .ow_valid  (ow_valid),
    .ow_pc     (ow_pc),
    .ow_instr  (ow_instr),
    .ow_result (ow_result),
    .ow_flags  (ow_flags)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic step();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input logic [15:0] instr);
    iw_valid = 1'b1;
    iw_op    = op;
    iw_opa   = a;
    iw_opb   = b;
    iw_pc    = pc;
    iw_instr = instr;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] res, input logic [1:0] flg,
                            input logic [15:0] pc, input logic [15:0] instr);
    check({tag, ".valid"}, ow_valid, 1);
    check({tag, ".result"}, ow_result, res);
    check({tag, ".flags"}, ow_flags, flg);
    check({tag, ".pc"}, ow_pc, pc);
    check({tag, ".instr"}, ow_instr, instr);
  endtask

  task automatic expect_bubble(input string tag, input logic stall);
    check({tag, ".valid"}, ow_valid, 0);
    check({tag, ".instr"}, ow_instr, 0);
    check({tag, ".stall"}, ow_stall, stall);
  endtask

  initial begin
    int stall_cycles;
    bit got;
    iw_rst_n = 1'b0;
    iw_valid = 1'b0;
    iw_flush = 1'b0;
    iw_op    = 3'd0;
    iw_opa   = '0;
    iw_opb   = '0;
    iw_pc    = '0;
    iw_instr = '0;

    // reset state
    #3;
    check("rst.stall", ow_stall, 0);
    check("rst.valid", ow_valid, 0);
    check("rst.result", ow_result, 0);
    check("rst.flags", ow_flags, 0);
    step();
    iw_rst_n = 1'b1;
    step();
    expect_bubble("idle", 0);
    check("idle.pc", ow_pc, 0);
    check("idle.result", ow_result, 0);

    // single-cycle ops back to back
    drive(3'd0, 16'h0005, 16'h0003, 16'h0100, 16'hA001); step();
    expect_out("add", 16'h0008, 2'b00, 16'h0100, 16'hA001);
    drive(3'd1, 16'h0003, 16'h0005, 16'h0102, 16'hA002); step();
    expect_out("sub", 16'hFFFE, 2'b01, 16'h0102, 16'hA002);
    drive(3'd4, 16'h1234, 16'h1234, 16'h0104, 16'hA003); step();
    expect_out("xor", 16'h0000, 2'b10, 16'h0104, 16'hA003);
    drive(3'd5, 16'h0001, 16'd16, 16'h0106, 16'hA004); step();
    expect_out("shl16", 16'h0000, 2'b10, 16'h0106, 16'hA004);
    drive(3'd6, 16'h8000, 16'd15, 16'h0108, 16'hA005); step();
    expect_out("shr15", 16'h0001, 2'b00, 16'h0108, 16'hA005);
    drive(3'd0, 16'hFFFF, 16'h0001, 16'h010A, 16'hA006); step();
    expect_out("addc", 16'h0000, 2'b11, 16'h010A, 16'hA006);
    drive(3'd2, 16'hF0F0, 16'h3C3C, 16'h010C, 16'hA007); step();
    expect_out("and", 16'h3030, 2'b00, 16'h010C, 16'hA007);
    drive(3'd3, 16'hF000, 16'h000F, 16'h010E, 16'hA008); step();
    expect_out("or", 16'hF00F, 2'b00, 16'h010E, 16'hA008);
    drive(3'd5, 16'h0003, 16'd4, 16'h0110, 16'hA009); step();
    expect_out("shl4", 16'h0030, 2'b00, 16'h0110, 16'hA009);

    // idle cycle: bubble, flags hold
    iw_valid = 1'b0; step();
    expect_bubble("gap", 0);
    check("gap.flags", ow_flags, 2'b00);

    // MUL 7*6 with ADD 1+1 held behind it
    drive(3'd7, 16'd7, 16'd6, 16'h0200, 16'hB001); step();
    expect_bubble("mul0", 1);
    drive(3'd0, 16'd1, 16'd1, 16'h0202, 16'hB002);
    for (int i = 1; i < 16; i++) begin
      step();
      expect_bubble($sformatf("mul%0d", i), 1);
    end
    step();
    check("mul.stall", ow_stall, 0);
    expect_out("mul", 16'h002A, 2'b00, 16'h0200, 16'hB001);
    step();
    check("held.stall", ow_stall, 0);
    expect_out("held", 16'h0002, 2'b00, 16'h0202, 16'hB002);

    // flush mid-MUL: flags from the XOR must survive
    drive(3'd4, 16'h00FF, 16'h00FF, 16'h0300, 16'hC001); step();
    expect_out("xor2", 16'h0000, 2'b10, 16'h0300, 16'hC001);
    drive(3'd7, 16'd5, 16'd5, 16'h0302, 16'hC002); step();
    iw_valid = 1'b0; step(); step();
    check("flushpre.stall", ow_stall, 1);
    drive(3'd0, 16'd9, 16'd9, 16'h0304, 16'hC003);
    iw_flush = 1'b1; step();
    expect_bubble("flush", 0);
    check("flush.flags", ow_flags, 2'b10);
    iw_flush = 1'b0;
    drive(3'd0, 16'd2, 16'd3, 16'h0306, 16'hC004); step();
    expect_out("postflush", 16'h0005, 2'b00, 16'h0306, 16'hC004);

    // asynchronous reset mid-MUL
    drive(3'd7, 16'd3, 16'd3, 16'h0400, 16'hD001); step();
    iw_valid = 1'b0; step(); step();
    #3;
    iw_rst_n = 1'b0;
    #1;
    check("arst.stall", ow_stall, 0);
    check("arst.valid", ow_valid, 0);
    check("arst.result", ow_result, 0);
    check("arst.flags", ow_flags, 0);
    check("arst.pc", ow_pc, 0);
    @(negedge iw_clk);
    iw_rst_n = 1'b1;

    // fresh MUL 3*3 with latency measured under a cycle budget
    @(posedge iw_clk); #1;
    drive(3'd7, 16'd3, 16'd3, 16'h0500, 16'hE001); step();
    iw_valid = 1'b0;
    stall_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ow_valid) got = 1'b1;
      else begin
        if (ow_stall) stall_cycles++;
        step();
      end
    end
    check("mul3.done", got, 1);
    check("mul3.stalls", stall_cycles, 16);
    expect_out("mul3", 16'h0009, 2'b00, 16'h0500, 16'hE001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
